// File: rtl/systolic_operand_feeder_if.sv
// Start handshake, tile/filter payload and operand streams between tile buffer, feeder and array.
// Tag outputs exist only when FEEDER_FRAME_TAG_EN is defined.
interface systolic_operand_feeder_if #(
    parameter int unsigned DATA_W = 8
);
    logic                  start;
    logic                  hold;
    logic [16*DATA_W-1:0]  i_flat;
    logic [9*DATA_W-1:0]   f_flat;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic                  mode;
    logic [DATA_W-1:0]     a0;
    logic [DATA_W-1:0]     a1;
    logic [DATA_W-1:0]     a2;
    logic [DATA_W-1:0]     b0;
    logic [DATA_W-1:0]     b1;
    logic [DATA_W-1:0]     b2;
`ifdef FEEDER_FRAME_TAG_EN
    logic                  tag_valid;
    logic                  tag_row;
    logic [1:0]            tag_col;
`endif

    modport master (
        output start, hold, i_flat, f_flat,
        input  ready, busy, done, mode, a0, a1, a2, b0, b1, b2
`ifdef FEEDER_FRAME_TAG_EN
        , input tag_valid, tag_row, tag_col
`endif
    );

    modport slave (
        input  start, hold, i_flat, f_flat,
        output ready, busy, done, mode, a0, a1, a2, b0, b1, b2
`ifdef FEEDER_FRAME_TAG_EN
        , output tag_valid, tag_row, tag_col
`endif
    );
endinterface

// File: rtl/systolic_operand_feeder.sv
// Weight preload and skewed input streaming for the 3x3 weight-stationary systolic array.
// Optional frame tags aligned with a0 under FEEDER_FRAME_TAG_EN.
module systolic_operand_feeder #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                     clk_in,
    input  logic                     rst,
    systolic_operand_feeder_if.slave bus
);
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned LOAD_LAST = 2;
    localparam int unsigned COMP_LAST = 9;
    localparam int unsigned S_LAST    = 7;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] i_reg [16];
    logic [DATA_W-1:0] f_reg [9];

    assign cnt_nxt   = cnt + CNT_W'(1);
    assign bus.ready = (state == IDLE) && !bus.hold;

    // Element for array row r at compute step t; row r lags row 0 by r cycles.
    function automatic logic [DATA_W-1:0] a_elem(input logic [CNT_W-1:0] t, input logic [1:0] r);
        logic [CNT_W-1:0] s;
        logic [1:0]       row;
        s   = t - CNT_W'(r);
        row = 2'(s[2]) + r;
        if ((t >= CNT_W'(r)) && (s <= CNT_W'(S_LAST)))
            return i_reg[{row, s[1:0]}];
        return '0;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.mode <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.a0   <= '0;
            bus.a1   <= '0;
            bus.a2   <= '0;
            bus.b0   <= '0;
            bus.b1   <= '0;
            bus.b2   <= '0;
`ifdef FEEDER_FRAME_TAG_EN
            bus.tag_valid <= 1'b0;
            bus.tag_row   <= 1'b0;
            bus.tag_col   <= 2'b0;
`endif
        end else if (!bus.hold) begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        for (int n = 0; n < 16; n++) i_reg[n] <= bus.i_flat[n*DATA_W +: DATA_W];
                        for (int n = 0; n < 9; n++)  f_reg[n] <= bus.f_flat[n*DATA_W +: DATA_W];
                        state    <= LOAD;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        // First beat comes straight from the port: bottom filter row first.
                        bus.b0   <= bus.f_flat[6*DATA_W +: DATA_W];
                        bus.b1   <= bus.f_flat[7*DATA_W +: DATA_W];
                        bus.b2   <= bus.f_flat[8*DATA_W +: DATA_W];
                    end
                end
                LOAD: begin
                    if (cnt == CNT_W'(LOAD_LAST)) begin
                        state    <= COMPUTE;
                        cnt      <= '0;
                        bus.mode <= 1'b1;
                        bus.b0   <= '0;
                        bus.b1   <= '0;
                        bus.b2   <= '0;
                        bus.a0   <= a_elem(CNT_W'(0), 2'd0);
                        bus.a1   <= a_elem(CNT_W'(0), 2'd1);
                        bus.a2   <= a_elem(CNT_W'(0), 2'd2);
`ifdef FEEDER_FRAME_TAG_EN
                        bus.tag_valid <= 1'b1;
                        bus.tag_row   <= 1'b0;
                        bus.tag_col   <= 2'b0;
`endif
                    end else begin
                        cnt <= cnt_nxt;
                        case (cnt)
                            CNT_W'(0): begin
                                bus.b0 <= f_reg[3];
                                bus.b1 <= f_reg[4];
                                bus.b2 <= f_reg[5];
                            end
                            default: begin
                                bus.b0 <= f_reg[0];
                                bus.b1 <= f_reg[1];
                                bus.b2 <= f_reg[2];
                            end
                        endcase
                    end
                end
                COMPUTE: begin
                    if (cnt == CNT_W'(COMP_LAST)) begin
                        state  <= DRAIN;
                        cnt    <= '0;
                        bus.a0 <= '0;
                        bus.a1 <= '0;
                        bus.a2 <= '0;
`ifdef FEEDER_FRAME_TAG_EN
                        bus.tag_valid <= 1'b0;
                        bus.tag_row   <= 1'b0;
                        bus.tag_col   <= 2'b0;
`endif
                    end else begin
                        cnt    <= cnt_nxt;
                        bus.a0 <= a_elem(cnt_nxt, 2'd0);
                        bus.a1 <= a_elem(cnt_nxt, 2'd1);
                        bus.a2 <= a_elem(cnt_nxt, 2'd2);
`ifdef FEEDER_FRAME_TAG_EN
                        bus.tag_valid <= (cnt_nxt <= CNT_W'(S_LAST));
                        bus.tag_row   <= (cnt_nxt <= CNT_W'(S_LAST)) && cnt_nxt[2];
                        bus.tag_col   <= (cnt_nxt <= CNT_W'(S_LAST)) ? cnt_nxt[1:0] : 2'b0;
`endif
                    end
                end
                DRAIN: begin
                    if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        bus.mode <= 1'b0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder: reset, streaming, hold, abort, back-to-back, idle hold.
module tb_systolic_operand_feeder;
    localparam int unsigned DATA_W = 8;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   errors = 0;
    int   checks = 0;

    systolic_operand_feeder_if #(.DATA_W(DATA_W)) bus ();

    systolic_operand_feeder #(.DATA_W(DATA_W), .DRAIN_CYCLES(4)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    // Expected outputs of the default tile, indexed by cycle after the accept cycle (0 unused).
    int exp_mode [19] = '{0, 0,0,0, 1,1,1,1,1,1,1,1,1,1, 1,1,1,1, 0};
    int exp_busy [19] = '{0, 1,1,1, 1,1,1,1,1,1,1,1,1,1, 1,1,1,1, 0};
    int exp_done [19] = '{0, 0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 1};
    int exp_a0   [19] = '{0, 0,0,0, 1,2,3,4,5,6,7,8,0,0, 0,0,0,0, 0};
    int exp_a1   [19] = '{0, 0,0,0, 0,5,6,7,8,9,10,11,12,0, 0,0,0,0, 0};
    int exp_a2   [19] = '{0, 0,0,0, 0,0,9,10,11,12,13,14,15,16, 0,0,0,0, 0};
    int exp_b0   [19] = '{0, 7,4,1, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0};
    int exp_b1   [19] = '{0, 8,5,2, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0};
    int exp_b2   [19] = '{0, 9,6,3, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0};
`ifdef FEEDER_FRAME_TAG_EN
    int exp_tv   [19] = '{0, 0,0,0, 1,1,1,1,1,1,1,1,0,0, 0,0,0,0, 0};
    int exp_tr   [19] = '{0, 0,0,0, 0,0,0,0,1,1,1,1,0,0, 0,0,0,0, 0};
    int exp_tc   [19] = '{0, 0,0,0, 0,1,2,3,0,1,2,3,0,0, 0,0,0,0, 0};
`endif

    // {mode, busy, done, a0, a1, a2, b0, b1, b2}
    function automatic logic [50:0] obs_vec();
        return {bus.mode, bus.busy, bus.done, bus.a0, bus.a1, bus.a2, bus.b0, bus.b1, bus.b2};
    endfunction

    function automatic logic [50:0] exp_vec(input int c);
        return {1'(exp_mode[c]), 1'(exp_busy[c]), 1'(exp_done[c]),
                8'(exp_a0[c]), 8'(exp_a1[c]), 8'(exp_a2[c]),
                8'(exp_b0[c]), 8'(exp_b1[c]), 8'(exp_b2[c])};
    endfunction

    task automatic set_tile(input int i_off, input int f_off);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus.i_flat[(4*r+c)*DATA_W +: DATA_W] = 8'(4*r + c + 1 + i_off);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                bus.f_flat[(3*r+c)*DATA_W +: DATA_W] = 8'(3*r + c + 1 + f_off);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        set_tile(0, 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (obs_vec() !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", obs_vec());
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", bus.ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        @(negedge clk_in);
        bus.start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk_in);
            checks++;
            if (obs_vec() !== exp_vec(c)) begin
                errors++;
                $display("FAIL stream_c%0d: got %h want %h", c, obs_vec(), exp_vec(c));
            end
`ifdef FEEDER_FRAME_TAG_EN
            checks++;
            if ({bus.tag_valid, bus.tag_row, bus.tag_col} !== {1'(exp_tv[c]), 1'(exp_tr[c]), 2'(exp_tc[c])}) begin
                errors++;
                $display("FAIL tag_c%0d: got %b%b%b want %0d%0d%0d", c, bus.tag_valid, bus.tag_row,
                         bus.tag_col, exp_tv[c], exp_tr[c], exp_tc[c]);
            end
`endif
            bus.start = 1'b0;
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready_c18: got %b want 1", bus.ready);
        end
    endtask

    task automatic test_hold();
        int orig;
        @(negedge clk_in);
        bus.start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk_in);
            orig = (c <= 6) ? c : ((c <= 9) ? 6 : c - 3);
            checks++;
            if (obs_vec() !== exp_vec(orig)) begin
                errors++;
                $display("FAIL hold_c%0d: got %h want %h", c, obs_vec(), exp_vec(orig));
            end
            bus.start = 1'b0;
            bus.hold  = (c >= 6 && c <= 8);
        end
        // Freeze the done pulse in IDLE.
        bus.hold = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle_ready: got %b want 0", bus.ready);
        end
        @(negedge clk_in);
        checks++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            errors++;
            $display("FAIL hold_done_frozen: got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
        end
        bus.hold = 1'b0;
        @(negedge clk_in);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL hold_done_release: got %b want 0", bus.done);
        end
    endtask

    task automatic test_abort();
        @(negedge clk_in);
        bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_in);
            checks++;
            if (c < 8) begin
                if (obs_vec() !== exp_vec(c)) begin
                    errors++;
                    $display("FAIL abort_c%0d: got %h want %h", c, obs_vec(), exp_vec(c));
                end
            end else begin
                if (obs_vec() !== 51'd0) begin
                    errors++;
                    $display("FAIL abort_cleared: got %h want 0", obs_vec());
                end
            end
            if (c == 5) begin
                checks++;
                if (bus.ready !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_ready_busy: got %b want 0", bus.ready);
                end
            end
            if (c == 8) begin
                checks++;
                if (bus.ready !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_ready_idle: got %b want 1", bus.ready);
                end
            end
            bus.start = (c == 5);
            rst       = (c == 7);
        end
        for (int c = 9; c <= 26; c++) begin
            @(negedge clk_in);
            checks++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                errors++;
                $display("FAIL abort_idle_c%0d: got busy=%b done=%b want 0 0", c, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [50:0] want;
        @(negedge clk_in);
        set_tile(0, 0);
        bus.start = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk_in);
            if (c <= 18) begin
                checks++;
                if (obs_vec() !== exp_vec(c)) begin
                    errors++;
                    $display("FAIL b2b_c%0d: got %h want %h", c, obs_vec(), exp_vec(c));
                end
            end
            if (c == 18) begin
                checks++;
                if (bus.ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_c18: got %b want 1", bus.ready);
                end
            end
            if (c == 19 || c == 22 || c == 24 || c == 36) begin
                case (c)
                    19:      want = {3'b010, 8'd0,  8'd0,  8'd0,  8'd23, 8'd24, 8'd25};
                    22:      want = {3'b110, 8'd33, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0};
                    24:      want = {3'b110, 8'd35, 8'd38, 8'd41, 8'd0,  8'd0,  8'd0};
                    default: want = {3'b001, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0};
                endcase
                checks++;
                if (obs_vec() !== want) begin
                    errors++;
                    $display("FAIL b2b_second_c%0d: got %h want %h", c, obs_vec(), want);
                end
            end
            if (c == 1) set_tile(32, 16);
            if (c == 19) bus.start = 1'b0;
        end
    endtask

    task automatic test_hold_idle();
        @(negedge clk_in);
        bus.start = 1'b1;
        bus.hold  = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold_ready: got %b want 0", bus.ready);
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk_in);
            checks++;
            if (obs_vec() !== 51'd0) begin
                errors++;
                $display("FAIL idle_hold_c%0d: got %h want 0", c, obs_vec());
            end
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({bus.busy, bus.ready} !== 2'b01) begin
            errors++;
            $display("FAIL idle_hold_release: got busy=%b ready=%b want 0 1", bus.busy, bus.ready);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_abort();
        test_back_to_back();
        test_hold_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
